// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Front-end fetch stage. Holds the fetch PC, issues one 32-bit read at a time
//   to the I-cache, and pushes each returned {pc, inst} pair into a circular
//   instruction queue that rename/dispatch drains. A redirect reloads the PC,
//   clears the queue, and discards any response still in flight.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_ready       memory can accept a new request
//   redirect_valid  flush queue and reload PC from redirect_pc this cycle
//   redirect_pc     new fetch PC (low two bits ignored)
//   ufp_addr        I-cache request address (always the current PC)
//   ufp_rmask       4'hF during the single request cycle, else 0
//   ufp_rdata       I-cache read data, qualified by ufp_resp
//   ufp_resp        I-cache response strobe
//   dequeue         consumer pops the head entry
//   inst_out        head instruction
//   pc_out          head PC
//   empty_out       queue empty
//   full_out        queue holds IQ_DEPTH entries
//   count_out       number of occupied entries
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter int unsigned            IQ_DEPTH   = 64,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(32'h1eceb000)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_ready,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic [ADDR_WIDTH-1:0]       ufp_addr,
    output logic [3:0]                  ufp_rmask,
    input  logic [INST_WIDTH-1:0]       ufp_rdata,
    input  logic                        ufp_resp,
    input  logic                        dequeue,
    output logic [INST_WIDTH-1:0]       inst_out,
    output logic [ADDR_WIDTH-1:0]       pc_out,
    output logic                        empty_out,
    output logic                        full_out,
    output logic [$clog2(IQ_DEPTH):0]   count_out
);

    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // One queue slot: fetch PC alongside the instruction it returned.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } iq_entry_t;

    // IDLE: nothing outstanding; WAIT: live request; DISCARD: stale request.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   empty_q, full_q;
    iq_entry_t              mem_q [IQ_DEPTH];

    logic                   issue_c;
    logic                   enq_c;
    logic                   deq_c;
    logic                   unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Issue only with a free slot so the response can always be enqueued.
    assign issue_c = (state_q == ST_IDLE) && mem_ready && !redirect_valid
                     && (count_q < CNT_W'(IQ_DEPTH));
    assign enq_c   = (state_q == ST_WAIT) && ufp_resp && !redirect_valid;
    assign deq_c   = dequeue && (count_q != '0) && !redirect_valid;

    // Next-state, PC and queue pointer logic; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ufp_resp)            state_d = ST_IDLE;
                else if (redirect_valid) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (ufp_resp) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_c) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + ADDR_WIDTH'(4);
            end
            if (deq_c) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, pointers, flags and queue storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(IQ_DEPTH));
            if (enq_c) begin
                mem_q[tail_q] <= {pc_q, ufp_rdata};
            end
        end
    end

    // Request strobe must accompany the issue decision in the same cycle.
    assign ufp_rmask = issue_c ? 4'hF : 4'h0;
    assign ufp_addr  = pc_q;

    // Head slot is shown directly; stale when empty.
    assign inst_out  = mem_q[head_q].inst;
    assign pc_out    = mem_q[head_q].pc;
    assign empty_out = empty_q;
    assign full_out  = full_q;
    assign count_out = count_q;

endmodule
